// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// slave = loader side, master = stream source / memory side.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: byte stream -> LE words -> imem write port,
// holds the core while loading and validates an XOR checksum.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA,
    S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [7:0]  chk_q, chk_d;
  logic [23:0] acc_q, acc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        rdy;
  logic        take;
  logic        last;
  logic [15:0] nlen;

  assign last = (wcnt_q == len_q);
  assign nlen = {bus.in_data, len_q[7:0]};
  assign take = bus.in_valid && rdy;

  // DATA pauses for one cycle after the final word so its strobe stays in DATA
  always_comb begin
    rdy = 1'b0;
    unique case (state_q)
      S_LEN0, S_LEN1, S_CHECK: rdy = 1'b1;
      S_DATA:                  rdy = !last;
      default:                 rdy = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    chk_d   = chk_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    // address stays on the last written word once the image is complete
    if (we_q && !last) addr_d = addr_q + 32'd4;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN0;
          len_d   = '0;
          wcnt_d  = '0;
          bcnt_d  = '0;
          chk_d   = '0;
          addr_d  = BASE_ADDR;
        end
      end
      S_LEN0: begin
        if (take) begin
          len_d[7:0] = bus.in_data;
          chk_d      = chk_q ^ bus.in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (take) begin
          len_d[15:8] = bus.in_data;
          chk_d       = chk_q ^ bus.in_data;
          if (32'(nlen) > DEPTH_WORDS) state_d = S_ERR;
          else if (nlen == 16'd0)      state_d = S_CHECK;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (take) begin
          chk_d  = chk_q ^ bus.in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wdata_d = {bus.in_data, acc_q};
            we_d    = 1'b1;
            wcnt_d  = wcnt_q + 16'd1;
          end else begin
            acc_d[{bcnt_q, 3'b000} +: 8] = bus.in_data;
          end
        end else if (we_q && last) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (take) begin
          state_d = (bus.in_data == chk_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      chk_q   <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      chk_q   <= chk_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);
  assign cpu_hold      = !(state_q == S_IDLE || state_q == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table vectors, corner sequences and random
// streams checked against a stream-level reference model.
module tb_imem_loader;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    int          nb;
    logic [7:0]  b [12];
    bit          e_done;
    bit          e_err;
    int          e_nw;
    logic [31:0] e_a [2];
    logic [31:0] e_d [2];
  } vec_t;

  logic clk = 1'b0;
  logic reset, start;
  logic cpu_hold, done, error;

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bus     (bus),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] got_a [$];
  logic [31:0] got_d [$];
  logic [31:0] ew_a  [$];
  logic [31:0] ew_d  [$];

  always @(negedge clk) begin
    if (bus.mem_we) begin
      got_a.push_back(bus.mem_addr);
      got_d.push_back(bus.mem_wdata);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected writes and verdict derived directly from the stream format
  task automatic model(input bq_t s, output bit ed, output bit ee);
    int n;
    logic [7:0] x;
    ew_a.delete();
    ew_d.delete();
    ed = 1'b0;
    ee = 1'b0;
    n = int'({s[1], s[0]});
    if (n > int'(DEPTH)) begin
      ee = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= s[i];
    for (int i = 0; i < n; i++) begin
      ew_a.push_back(BASE + 32'(4 * i));
      ew_d.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
    end
    if (s[2+4*n] == x) ed = 1'b1;
    else ee = 1'b1;
  endtask

  task automatic send(input bq_t s, input int gap);
    foreach (s[i]) begin
      int t;
      bit r;
      while ($urandom_range(99) < gap) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      t = 0;
      do begin
        r = bus.in_ready;
        @(negedge clk);
        t++;
      end while (!r && t < 50);
      if (!r) begin
        nvec++;
        nmis++;
        $display("FAIL send: byte %0d not accepted within 50 cycles", i);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input bq_t s, input int gap, input bit ed, input bit ee, input string tag);
    int m;
    got_a.delete();
    got_d.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, ".arm"}, 64'({bus.in_ready, cpu_hold, done, error}), 64'(4'b1100));
    send(s, gap);
    repeat (2) @(negedge clk);
    chk({tag, ".nw"}, 64'(got_a.size()), 64'(ew_a.size()));
    m = (got_a.size() < ew_a.size()) ? got_a.size() : ew_a.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s.a%0d", tag, i), 64'(got_a[i]), 64'(ew_a[i]));
      chk($sformatf("%s.d%0d", tag, i), 64'(got_d[i]), 64'(ew_d[i]));
    end
    chk({tag, ".res"}, 64'({done, error, cpu_hold}), 64'({ed, ee, ee}));
  endtask

  task automatic rand_stream(input int n, input bit bad, output bq_t s);
    logic [7:0] x;
    s.delete();
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    if (n > int'(DEPTH)) return;
    for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
    x = 8'h00;
    foreach (s[i]) x ^= s[i];
    s.push_back(bad ? (x ^ 8'(1 + $urandom_range(254))) : x);
  endtask

  vec_t tbl [5];

  initial begin
    bq_t s;
    bit ed, ee;

    tbl[0] = '{11, '{8'h02,8'h00,8'h13,8'h00,8'h50,8'h00,8'h93,8'h00,8'hA0,8'h00,8'h72,8'h00},
               1'b1, 1'b0, 2, '{32'h0, 32'h4}, '{32'h0050_0013, 32'h00A0_0093}};
    tbl[1] = '{11, '{8'h02,8'h00,8'h13,8'h00,8'h50,8'h00,8'h93,8'h00,8'hA0,8'h00,8'h71,8'h00},
               1'b0, 1'b1, 2, '{32'h0, 32'h4}, '{32'h0050_0013, 32'h00A0_0093}};
    tbl[2] = '{2, '{8'h01,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
               1'b0, 1'b1, 0, '{32'h0, 32'h0}, '{32'h0, 32'h0}};
    tbl[3] = '{3, '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
               1'b1, 1'b0, 0, '{32'h0, 32'h0}, '{32'h0, 32'h0}};
    tbl[4] = '{3, '{8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
               1'b0, 1'b1, 0, '{32'h0, 32'h0}, '{32'h0, 32'h0}};

    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset", 64'({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold, done, error}), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle", 64'({bus.in_ready, cpu_hold, done, error}), 64'(0));

    // pass 0 back-to-back, pass 1 with random in_valid gaps
    for (int p = 0; p < 2; p++) begin
      for (int v = 0; v < 5; v++) begin
        s.delete();
        for (int k = 0; k < tbl[v].nb; k++) s.push_back(tbl[v].b[k]);
        ew_a.delete();
        ew_d.delete();
        for (int k = 0; k < tbl[v].e_nw; k++) begin
          ew_a.push_back(tbl[v].e_a[k]);
          ew_d.push_back(tbl[v].e_d[k]);
        end
        run(s, p * 50, tbl[v].e_done, tbl[v].e_err, $sformatf("tbl%0d.p%0d", v, p));
      end
    end

    // bytes offered while DONE are ignored
    rand_stream(1, 1'b0, s);
    model(s, ed, ee);
    run(s, 0, ed, ee, "pre_ign");
    got_a.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ign.state", 64'({bus.in_ready, done, error, cpu_hold}), 64'(4'b0100));
    chk("ign.nw", 64'(got_a.size()), 64'(0));

    // reset right after the 6th byte of the first table stream
    s.delete();
    for (int k = 0; k < 6; k++) s.push_back(tbl[0].b[k]);
    got_a.delete();
    got_d.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    send(s, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst.out", 64'({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold, done, error}), 64'(0));
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst.nw", 64'(got_a.size()), 64'(1));
    if (got_d.size() > 0) chk("rst.w0", 64'(got_d[0]), 64'(32'h0050_0013));
    s.delete();
    for (int k = 0; k < 11; k++) s.push_back(tbl[0].b[k]);
    model(s, ed, ee);
    run(s, 0, ed, ee, "rst.again");

    for (int r = 0; r < 16; r++) begin
      int n;
      n = ($urandom_range(5) == 0) ? 1025 + $urandom_range(64000) : $urandom_range(6);
      rand_stream(n, ($urandom_range(2) == 0), s);
      model(s, ed, ee);
      run(s, 40, ed, ee, $sformatf("rnd%0d", r));
    end

    rand_stream(int'(DEPTH), 1'b0, s);
    model(s, ed, ee);
    run(s, 0, ed, ee, "full");
    chk("full.last", 64'(bus.mem_addr), 64'(BASE + 32'(4 * (DEPTH - 1))));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
